ysyx_25040101_lsu: RTL and testbench

Load/store unit for nebula-core-B; it consumes the ALU result as an effective address. It accepts one memory operation at a time from the execute stage and issues a single request on the core's simple memory bus. It aligns and extends load data, or lane-replicates and strobes store data, and hands the completed result to writeback through a valid/ready handshake. Non-memory operations pass the ALU result straight through in one cycle.

---
 rtl/ysyx_25040101_lsu_pkg.sv | 26 ++
 rtl/ysyx_25040101_lsu_fmt.sv | 72 +++++++
 rtl/ysyx_25040101_lsu.sv | 110 +++++++++++
 tb/tb_ysyx_25040101_lsu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040101_lsu_pkg.sv
// Shared definitions for the nebula-core-B load/store unit: op encodings, FSM states and helpers.
package ysyx_25040101_lsu_pkg;

    localparam int STRB_W = 4;

    // One-hot memory op encoding, identical to the ctrl_unit output.
    localparam logic [7:0] MEM_LB  = 8'b0000_0001;
    localparam logic [7:0] MEM_LH  = 8'b0000_0010;
    localparam logic [7:0] MEM_LW  = 8'b0000_0100;
    localparam logic [7:0] MEM_LBU = 8'b0000_1000;
    localparam logic [7:0] MEM_LHU = 8'b0001_0000;
    localparam logic [7:0] MEM_SB  = 8'b0010_0000;
    localparam logic [7:0] MEM_SH  = 8'b0100_0000;
    localparam logic [7:0] MEM_SW  = 8'b1000_0000;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_RESP = 2'd2;
    localparam lsu_state_t ST_DONE = 2'd3;

    function automatic logic is_one_hot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/ysyx_25040101_lsu_fmt.sv
// Combinational load extract/extend and store replicate/strobe for the LSU.
// YSYX_25040101_LSU_MISALIGN_CHK_EN enables the misalignment flag; otherwise it is tied low.
module ysyx_25040101_lsu_fmt
    import ysyx_25040101_lsu_pkg::*;
(
    input  logic [7:0]        ctrl,
    input  logic [1:0]        offset,
    input  logic [31:0]       store_data,
    input  logic [31:0]       rdata,
    output logic [31:0]       load_data,
    output logic [31:0]       wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wen,
    output logic              misaligned
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    // Halfword lanes only look at offset[1]; words are never shifted.
    always_comb begin
        byte_shift = rdata >> {offset, 3'b000};
        half_shift = rdata >> {offset[1], 4'b0000};
        load_data  = 32'd0;
        case (ctrl)
            MEM_LB:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            MEM_LH:  load_data = {{16{half_shift[15]}}, half_shift[15:0]};
            MEM_LW:  load_data = rdata;
            MEM_LBU: load_data = {24'd0, byte_shift[7:0]};
            MEM_LHU: load_data = {16'd0, half_shift[15:0]};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        wdata = 32'd0;
        wstrb = '0;
        wen   = ctrl[5] | ctrl[6] | ctrl[7];
        case (ctrl)
            MEM_SB: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << offset;
            end
            MEM_SH: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << {offset[1], 1'b0};
            end
            MEM_SW: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
            default: begin
                wdata = 32'd0;
                wstrb = '0;
            end
        endcase
    end

`ifdef YSYX_25040101_LSU_MISALIGN_CHK_EN
    always_comb begin
        misaligned = 1'b0;
        case (ctrl)
            MEM_LH, MEM_LHU, MEM_SH: misaligned = offset[0];
            MEM_LW, MEM_SW:          misaligned = |offset;
            default:                 misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/ysyx_25040101_lsu.sv
// Load/store unit: one op at a time, single request on the simple memory bus, valid/ready to writeback.
// Optional misalignment trap via YSYX_25040101_LSU_MISALIGN_CHK_EN (see ysyx_25040101_lsu_fmt).
module ysyx_25040101_lsu
    import ysyx_25040101_lsu_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       store_data_i,
    input  logic [7:0]        mem_ctrl_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_wen_o,
    output logic [31:0]       req_addr_o,
    output logic [31:0]       req_wdata_o,
    output logic [STRB_W-1:0] req_wstrb_o,
    input  logic              resp_valid_i,
    output logic              resp_ready_o,
    input  logic [31:0]       resp_rdata_i,
    input  logic              resp_err_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       result_o,
    output logic              err_o
);

    lsu_state_t        state;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [31:0]       result_q;
    logic [7:0]        ctrl_q;
    logic              err_q;

    logic [7:0]        fmt_ctrl;
    logic [1:0]        fmt_offset;
    logic [31:0]       load_data;
    logic [31:0]       fmt_wdata;
    logic [STRB_W-1:0] fmt_wstrb;
    logic              fmt_wen;
    logic              misaligned;

    // In IDLE the formatter sees the incoming op so the alignment check can gate the accept.
    assign fmt_ctrl   = (state == ST_IDLE) ? mem_ctrl_i : ctrl_q;
    assign fmt_offset = (state == ST_IDLE) ? alu_result_i[1:0] : addr_q[1:0];

    ysyx_25040101_lsu_fmt u_fmt (
        .ctrl       (fmt_ctrl),
        .offset     (fmt_offset),
        .store_data (data_q),
        .rdata      (resp_rdata_i),
        .load_data  (load_data),
        .wdata      (fmt_wdata),
        .wstrb      (fmt_wstrb),
        .wen        (fmt_wen),
        .misaligned (misaligned)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            ctrl_q   <= 8'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (valid_i) begin
                    addr_q   <= alu_result_i;
                    data_q   <= store_data_i;
                    ctrl_q   <= mem_ctrl_i;
                    result_q <= 32'd0;
                    err_q    <= 1'b0;
                    if (mem_ctrl_i == 8'd0) begin
                        result_q <= alu_result_i;
                        state    <= ST_DONE;
                    end else if (!is_one_hot(mem_ctrl_i) || misaligned) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ:  if (req_ready_i) state <= ST_RESP;
                // Stores format to zero here, which is their writeback result.
                ST_RESP: if (resp_valid_i) begin
                    result_q <= load_data;
                    err_q    <= resp_err_i;
                    state    <= ST_DONE;
                end
                ST_DONE: if (ready_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready_o      = (state == ST_IDLE);
    assign req_valid_o  = (state == ST_REQ);
    assign req_wen_o    = req_valid_o & fmt_wen;
    assign req_addr_o   = req_valid_o ? {addr_q[31:2], 2'b00} : 32'd0;
    assign req_wdata_o  = req_wen_o ? fmt_wdata : 32'd0;
    assign req_wstrb_o  = req_wen_o ? fmt_wstrb : '0;
    assign resp_ready_o = (state == ST_RESP);
    assign valid_o      = (state == ST_DONE);
    assign result_o     = valid_o ? result_q : 32'd0;
    assign err_o        = valid_o & err_q;

endmodule

// File: tb/tb_ysyx_25040101_lsu.sv
// Directed self-checking bench for ysyx_25040101_lsu; expected values are hand-computed.
module tb_ysyx_25040101_lsu;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic [7:0]  mem_ctrl_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        req_wen_o;
    logic [31:0] req_addr_o;
    logic [31:0] req_wdata_o;
    logic [3:0]  req_wstrb_o;
    logic        resp_valid_i;
    logic        resp_ready_o;
    logic [31:0] resp_rdata_i;
    logic        resp_err_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        err_o;

    int tests = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ysyx_25040101_lsu dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .mem_ctrl_i   (mem_ctrl_i),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_wen_o    (req_wen_o),
        .req_addr_o   (req_addr_o),
        .req_wdata_o  (req_wdata_o),
        .req_wstrb_o  (req_wstrb_o),
        .resp_valid_i (resp_valid_i),
        .resp_ready_o (resp_ready_o),
        .resp_rdata_i (resp_rdata_i),
        .resp_err_i   (resp_err_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .err_o        (err_o)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one op for a single cycle; returns one cycle after the accept edge (c1).
    task automatic applyStimulus(input logic [7:0] ctrl, input logic [31:0] addr, input logic [31:0] sdata);
        valid_i      = 1'b1;
        mem_ctrl_i   = ctrl;
        alu_result_i = addr;
        store_data_i = sdata;
        tick();
        valid_i      = 1'b0;
        mem_ctrl_i   = 8'd0;
        alu_result_i = 32'd0;
        store_data_i = 32'd0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".ready_o"},      32'(ready_o),      32'd1);
        checkOutput({tag, ".req_valid_o"},  32'(req_valid_o),  32'd0);
        checkOutput({tag, ".req_wen_o"},    32'(req_wen_o),    32'd0);
        checkOutput({tag, ".resp_ready_o"}, 32'(resp_ready_o), 32'd0);
        checkOutput({tag, ".valid_o"},      32'(valid_o),      32'd0);
        checkOutput({tag, ".err_o"},        32'(err_o),        32'd0);
        checkOutput({tag, ".req_addr_o"},   req_addr_o,        32'd0);
        checkOutput({tag, ".req_wdata_o"},  req_wdata_o,       32'd0);
        checkOutput({tag, ".req_wstrb_o"},  32'(req_wstrb_o),  32'd0);
        checkOutput({tag, ".result_o"},     result_o,          32'd0);
    endtask

    // Zero-wait bus: request at c1, response at c2, result at c3, idle again at c4.
    task automatic runZeroWait(input string tag, input logic [7:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] rdata, input logic rerr,
                               input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                               input logic [3:0] exp_wstrb, input logic exp_wen,
                               input logic [31:0] exp_result, input logic exp_err);
        req_ready_i  = 1'b1;
        resp_valid_i = 1'b1;
        resp_rdata_i = rdata;
        resp_err_i   = rerr;
        ready_i      = 1'b1;
        applyStimulus(ctrl, addr, sdata);
        checkOutput({tag, ".c1.req_valid_o"}, 32'(req_valid_o), 32'd1);
        checkOutput({tag, ".c1.req_addr_o"},  req_addr_o,       exp_addr);
        checkOutput({tag, ".c1.req_wdata_o"}, req_wdata_o,      exp_wdata);
        checkOutput({tag, ".c1.req_wstrb_o"}, 32'(req_wstrb_o), 32'(exp_wstrb));
        checkOutput({tag, ".c1.req_wen_o"},   32'(req_wen_o),   32'(exp_wen));
        tick();
        checkOutput({tag, ".c2.resp_ready_o"}, 32'(resp_ready_o), 32'd1);
        checkOutput({tag, ".c2.req_valid_o"},  32'(req_valid_o),  32'd0);
        tick();
        checkOutput({tag, ".c3.valid_o"},  32'(valid_o), 32'd1);
        checkOutput({tag, ".c3.result_o"}, result_o,     exp_result);
        checkOutput({tag, ".c3.err_o"},    32'(err_o),   32'(exp_err));
        tick();
        checkOutput({tag, ".c4.ready_o"}, 32'(ready_o), 32'd1);
        resp_valid_i = 1'b0;
        resp_err_i   = 1'b0;
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        valid_i      = 1'b0;
        alu_result_i = 32'd0;
        store_data_i = 32'd0;
        mem_ctrl_i   = 8'd0;
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_rdata_i = 32'd0;
        resp_err_i   = 1'b0;
        ready_i      = 1'b1;
        tick();
        tick();
        checkResetOutputs("reset");
        reset_n = 1'b1;
        tick();

        // Non-memory pass-through: result at c1, no bus activity.
        applyStimulus(8'd0, 32'h1234_5678, 32'd0);
        checkOutput("nonmem.valid_o",     32'(valid_o),     32'd1);
        checkOutput("nonmem.result_o",    result_o,         32'h1234_5678);
        checkOutput("nonmem.req_valid_o", 32'(req_valid_o), 32'd0);
        checkOutput("nonmem.ready_o",     32'(ready_o),     32'd0);
        checkOutput("nonmem.err_o",       32'(err_o),       32'd0);
        tick();
        checkOutput("nonmem.idle", 32'(ready_o), 32'd1);

        runZeroWait("lb",  8'h01, 32'h8000_0003, 32'd0, 32'h80AA_BBCC, 1'b0,
                    32'h8000_0000, 32'd0, 4'b0000, 1'b0, 32'hFFFF_FF80, 1'b0);
        runZeroWait("sh",  8'h40, 32'h8000_0002, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0,
                    32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 1'b1, 32'd0, 1'b0);
        runZeroWait("lh",  8'h02, 32'h8000_0002, 32'd0, 32'h8001_7FFF, 1'b0,
                    32'h8000_0000, 32'd0, 4'b0000, 1'b0, 32'hFFFF_8001, 1'b0);
        runZeroWait("lhu", 8'h10, 32'h8000_0000, 32'd0, 32'h8001_7FFF, 1'b0,
                    32'h8000_0000, 32'd0, 4'b0000, 1'b0, 32'h0000_7FFF, 1'b0);
        runZeroWait("sb",  8'h20, 32'h8000_0001, 32'h1234_56A5, 32'd0, 1'b0,
                    32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 1'b1, 32'd0, 1'b0);
        runZeroWait("sw",  8'h80, 32'h8000_000C, 32'h1234_5678, 32'd0, 1'b0,
                    32'h8000_000C, 32'h1234_5678, 4'b1111, 1'b1, 32'd0, 1'b0);
        runZeroWait("lwerr", 8'h04, 32'h8000_0004, 32'd0, 32'hCAFE_F00D, 1'b1,
                    32'h8000_0004, 32'd0, 4'b0000, 1'b0, 32'hCAFE_F00D, 1'b1);

        // Stalled bus: request held c1..c4, response waits c5..c6, result at c8.
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b1;
        resp_rdata_i = 32'h1122_3344;
        ready_i      = 1'b1;
        applyStimulus(8'h08, 32'h8000_0001, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            checkOutput($sformatf("stall.c%0d.req_valid_o", k), 32'(req_valid_o), 32'd1);
            checkOutput($sformatf("stall.c%0d.req_addr_o", k),  req_addr_o,       32'h8000_0000);
            checkOutput($sformatf("stall.c%0d.valid_o", k),     32'(valid_o),     32'd0);
            tick();
        end
        checkOutput("stall.c4.req_valid_o", 32'(req_valid_o), 32'd1);
        req_ready_i  = 1'b1;
        resp_valid_i = 1'b0;
        tick();
        req_ready_i = 1'b0;
        checkOutput("stall.c5.resp_ready_o", 32'(resp_ready_o), 32'd1);
        checkOutput("stall.c5.valid_o",      32'(valid_o),      32'd0);
        tick();
        checkOutput("stall.c6.resp_ready_o", 32'(resp_ready_o), 32'd1);
        tick();
        resp_valid_i = 1'b1;
        ready_i      = 1'b0;
        tick();
        resp_valid_i = 1'b0;
        checkOutput("stall.c8.valid_o",  32'(valid_o), 32'd1);
        checkOutput("stall.c8.result_o", result_o,     32'h0000_0033);
        tick();
        checkOutput("stall.c9.valid_o",  32'(valid_o), 32'd1);
        checkOutput("stall.c9.result_o", result_o,     32'h0000_0033);
        ready_i = 1'b1;
        tick();
        checkOutput("stall.c10.ready_o", 32'(ready_o), 32'd1);

        // Illegal (multi-hot) ctrl: error at c1, no request.
        applyStimulus(8'b0000_0011, 32'h8000_0000, 32'd0);
        checkOutput("illegal.valid_o",     32'(valid_o),     32'd1);
        checkOutput("illegal.err_o",       32'(err_o),       32'd1);
        checkOutput("illegal.req_valid_o", 32'(req_valid_o), 32'd0);
        tick();

`ifdef YSYX_25040101_LSU_MISALIGN_CHK_EN
        applyStimulus(8'h04, 32'h8000_0002, 32'd0);
        checkOutput("mislw.valid_o",     32'(valid_o),     32'd1);
        checkOutput("mislw.err_o",       32'(err_o),       32'd1);
        checkOutput("mislw.result_o",    result_o,         32'd0);
        checkOutput("mislw.req_valid_o", 32'(req_valid_o), 32'd0);
        tick();
`else
        runZeroWait("mislw", 8'h04, 32'h8000_0002, 32'd0, 32'h1122_3344, 1'b0,
                    32'h8000_0000, 32'd0, 4'b0000, 1'b0, 32'h1122_3344, 1'b0);
`endif

        // Reset asserted while waiting in RESP abandons the op.
        req_ready_i  = 1'b1;
        resp_valid_i = 1'b0;
        applyStimulus(8'h04, 32'h8000_0010, 32'd0);
        tick();
        checkOutput("rstresp.resp_ready_o", 32'(resp_ready_o), 32'd1);
        reset_n = 1'b0;
        tick();
        checkResetOutputs("rstresp");
        reset_n      = 1'b1;
        resp_valid_i = 1'b1;
        tick();
        checkOutput("rstresp.stray.valid_o", 32'(valid_o), 32'd0);
        checkOutput("rstresp.stray.ready_o", 32'(ready_o), 32'd1);
        resp_valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
